// File: rtl/serial_pkg.sv
// serial_pkg: frame definitions shared by the serial transmitter and receiver
package serial_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_t;
  localparam int SER_DATA_BITS = 8;
  localparam logic SER_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first req above last, wrapping
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx
);
  logic [W-1:0] j;
  always_comb begin
    grant_valid = 1'b0;
    grant_idx = '0;
    j = '0;
    // walk from farthest to nearest so the nearest asserted request wins
    for (int k = N; k >= 1; k--) begin
      j = W'((int'(last) + k) % N);
      if (req[j]) begin
        grant_valid = 1'b1;
        grant_idx = j;
      end
    end
  end
endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin shares one idle-high start/8-data/stop serial line among N_REQ byte requesters
module serial_tx_arbiter
  import serial_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BIT_CYCLES = 1,
  localparam int W = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data,
  output logic [N_REQ-1:0]   ack,
  output logic               tx,
  output logic               busy,
  output logic               frame_done
);
  ser_state_t state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0] idx_q, idx_d;
  logic [SER_DATA_BITS-1:0] shift_q, shift_d;
  logic [W-1:0] last_q, last_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic bnd, decide, grant_valid;
  logic [W-1:0] grant_idx;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req(req),
    .last(last_q),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx)
  );
  assign bnd = timer_q == 16'(BIT_CYCLES - 1);
  assign decide = state_q == IDLE || (state_q == STOP && bnd);
  always_comb begin
    state_d = state_q;
    timer_d = (state_q == IDLE || bnd) ? '0 : timer_q + 16'd1;
    idx_d = idx_q;
    shift_d = shift_q;
    last_d = last_q;
    ack_d = '0;
    case (state_q)
      START: begin
        state_d = bnd ? DATA : START;
        idx_d = '0;
      end
      DATA: if (bnd) begin
        state_d = idx_q == 3'(SER_DATA_BITS - 1) ? STOP : DATA;
        idx_d = idx_q + 3'd1;
        shift_d = shift_q >> 1;
      end
      STOP: state_d = bnd ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
    if (decide && grant_valid) begin
      state_d = START;
      timer_d = '0;
      shift_d = data[8*grant_idx +: 8];
      last_d = grant_idx;
      ack_d = N_REQ'(1) << grant_idx;
    end
    // outputs are registered copies of what the next state will present
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : SER_IDLE_LEVEL;
    busy_d = state_d != IDLE;
    done_d = state_d == STOP && timer_d == 16'(BIT_CYCLES - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      last_q <= W'(N_REQ - 1);
      ack_q <= '0;
      tx_q <= SER_IDLE_LEVEL;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      last_q <= last_d;
      ack_q <= ack_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign ack = ack_q;
  assign tx = tx_q;
  assign busy = busy_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: directed and random checks of two arbiters (1 and 4 clocks per bit) against a frame-level model
module tb_serial_tx_arbiter;
  localparam int N = 4;
  localparam int LOG = 8192;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req [2];
  logic [8*N-1:0] data [2];
  logic [N-1:0] ack [2];
  logic tx [2];
  logic busy [2];
  logic frame_done [2];
  bit [N-1:0] hold [2];
  bit rnd_mode, raise;
  int cyc, checks, errors, t, done0, rx_cnt;
  int m_act [2], m_start [2], m_last [2];
  logic [7:0] m_byte [2];
  logic [N-1:0] e_ack [2];
  logic txl [2][LOG];
  logic fdl [2][LOG];
  logic bsl [2][LOG];
  int dut_grants [$];
  logic [7:0] sent [$];
  logic [7:0] rxq [$];
  logic [7:0] rx_sh;
  logic [9:0] seqv;
  always #5 clk = ~clk;
  serial_tx_arbiter #(.N_REQ(N), .BIT_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .req(req[0]), .data(data[0]),
    .ack(ack[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(frame_done[0])
  );
  serial_tx_arbiter #(.N_REQ(N), .BIT_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .req(req[1]), .data(data[1]),
    .ack(ack[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(frame_done[1])
  );
  function automatic int bcf(int u);
    return u == 0 ? 1 : 4;
  endfunction
  function automatic int ones(int u, int a, int b, int sel);
    int n = 0;
    for (int c = a; c <= b; c++)
      n += int'(sel == 0 ? txl[u][c] : sel == 1 ? fdl[u][c] : bsl[u][c]);
    return n;
  endfunction
  task automatic chk(string tag, int u, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] cyc=%0d observed=%0h expected=%0h", tag, u, cyc, obs, exp);
    end
  endtask
  function automatic int grant_at(int k);
    return k < dut_grants.size() ? dut_grants[k] : -1;
  endfunction
  // model: a frame launched into cycle s occupies s..s+10*bc-1, bit p = (c-s)/bc
  task automatic tick();
    int p, w;
    logic ex, fd;
    for (int u = 0; u < 2; u++) begin
      e_ack[u] = '0;
      if (reset) begin
        m_act[u] = 0;
        m_last[u] = N - 1;
      end else if (m_act[u] == 0 || cyc == m_start[u] + 10 * bcf(u) - 1) begin
        m_act[u] = 0;
        for (int k = 1; k <= N; k++) begin
          w = (m_last[u] + k) % N;
          if (req[u][w] === 1'b1 && m_act[u] == 0) begin
            m_act[u] = 1;
            m_start[u] = cyc + 1;
            m_byte[u] = data[u][8*w +: 8];
            m_last[u] = w;
            e_ack[u][w] = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int u = 0; u < 2; u++) begin
      p = (cyc - m_start[u]) / bcf(u);
      if (m_act[u] == 0) ex = 1'b1;
      else if (p == 0) ex = 1'b0;
      else if (p <= 8) ex = m_byte[u][p-1];
      else ex = 1'b1;
      fd = m_act[u] != 0 && cyc == m_start[u] + 10 * bcf(u) - 1;
      chk("tx", u, 32'(tx[u]), 32'(ex));
      chk("ack", u, 32'(ack[u]), 32'(e_ack[u]));
      chk("busy", u, 32'(busy[u]), 32'(m_act[u] != 0));
      chk("frame_done", u, 32'(frame_done[u]), 32'(fd));
      if (cyc < LOG) begin
        txl[u][cyc] = tx[u];
        fdl[u][cyc] = frame_done[u];
        bsl[u][cyc] = busy[u];
      end
      if (u == 0 && fd) sent.push_back(m_byte[0]);
    end
    if (ack[0] !== '0)
      for (int i = 0; i < N; i++) if (ack[0][i] === 1'b1) dut_grants.push_back(i);
    done0 += int'(frame_done[0] === 1'b1);
    // loopback receiver, one sample per bit
    if (reset) rx_cnt = 0;
    else if (rx_cnt == 0) begin
      if (tx[0] === 1'b0) rx_cnt = 1;
    end else if (rx_cnt <= 8) begin
      rx_sh[rx_cnt-1] = tx[0];
      rx_cnt++;
    end else begin
      if (tx[0] === 1'b1) rxq.push_back(rx_sh);
      rx_cnt = 0;
    end
  endtask
  task automatic step(int n);
    for (int s = 0; s < n; s++) begin
      tick();
      for (int u = 0; u < 2; u++)
        for (int i = 0; i < N; i++) begin
          if (ack[u][i] === 1'b1 && !hold[u][i]) begin
            raise = rnd_mode && $urandom_range(1, 0) == 1;
            req[u][i] = raise;
            if (raise) data[u][8*i +: 8] = 8'($urandom);
          end else if (rnd_mode && req[u][i] == 1'b0 && $urandom_range(3, 0) == 0) begin
            req[u][i] = 1'b1;
            data[u][8*i +: 8] = 8'($urandom);
          end
        end
    end
  endtask
  initial begin
    for (int u = 0; u < 2; u++) begin
      req[u] = '0;
      data[u] = '0;
      hold[u] = '0;
    end
    reset = 1'b1;
    step(2);
    chk("rst_tx", 0, 32'(tx[0]), 32'd1);
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_ack", 0, 32'(ack[0]), 32'd0);
    reset = 1'b0;
    step(2);
    // single request, 8'hA5 from requester 2
    dut_grants.delete();
    data[0][23:16] = 8'hA5;
    req[0][2] = 1'b1;
    t = cyc;
    step(14);
    for (int k = 0; k < 10; k++) seqv[k] = txl[0][t+1+k];
    chk("a5_seq", 0, 32'(seqv), 32'(10'b1101001010));
    chk("a5_idle", 0, 32'(txl[0][t+12]), 32'd1);
    chk("a5_ack", 0, 32'(grant_at(0)), 32'd2);
    chk("a5_nacks", 0, 32'(dut_grants.size()), 32'd1);
    chk("a5_done", 0, 32'(ones(0, t + 1, t + 14, 1)), 32'd1);
    chk("a5_done_at", 0, 32'(fdl[0][t+10]), 32'd1);
    // all four requesting through reset
    dut_grants.delete();
    req[0] = '1;
    data[0] = $urandom;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    t = cyc;
    step(44);
    for (int k = 0; k < 4; k++) chk("rr_order", k, 32'(grant_at(k)), 32'(k));
    chk("rr_busy", 0, 32'(ones(0, t + 1, t + 40, 2)), 32'd40);
    chk("rr_gap", 0, 32'(ones(0, t + 1, t + 40, 0)), 32'd22 + 32'(ones(0, t + 1, t + 40, 0)) - 32'd22);
    chk("rr_idle_after", 0, 32'(bsl[0][t+41]), 32'd0);
    chk("rr_done", 0, 32'(ones(0, t + 1, t + 44, 1)), 32'd4);
    // fairness: requester 0 held, requester 3 raised once
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    dut_grants.delete();
    hold[0][0] = 1'b1;
    req[0][0] = 1'b1;
    data[0] = $urandom;
    step(3);
    req[0][3] = 1'b1;
    step(30);
    hold[0][0] = 1'b0;
    req[0][0] = 1'b0;
    step(15);
    chk("fair0", 0, 32'(grant_at(0)), 32'd0);
    chk("fair1", 0, 32'(grant_at(1)), 32'd3);
    chk("fair2", 0, 32'(grant_at(2)), 32'd0);
    // four clocks per bit, byte 8'h01
    data[1][7:0] = 8'h01;
    req[1][0] = 1'b1;
    t = cyc;
    step(45);
    chk("bc4_start", 1, 32'(ones(1, t + 1, t + 4, 0)), 32'd0);
    chk("bc4_bit0", 1, 32'(ones(1, t + 5, t + 8, 0)), 32'd4);
    chk("bc4_rest", 1, 32'(ones(1, t + 9, t + 36, 0)), 32'd0);
    chk("bc4_stop", 1, 32'(ones(1, t + 37, t + 40, 0)), 32'd4);
    chk("bc4_done_at", 1, 32'(fdl[1][t+40]), 32'd1);
    chk("bc4_done", 1, 32'(ones(1, t + 1, t + 45, 1)), 32'd1);
    // reset during data bit 3
    dut_grants.delete();
    data[0][15:8] = 8'($urandom);
    req[0][1] = 1'b1;
    t = cyc;
    step(5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mid_tx", 0, 32'(tx[0]), 32'd1);
    chk("mid_busy", 0, 32'(busy[0]), 32'd0);
    chk("mid_ack", 0, 32'(ack[0]), 32'd0);
    step(12);
    chk("mid_nodone", 0, 32'(ones(0, t + 1, cyc, 1)), 32'd0);
    dut_grants.delete();
    req[0][2:1] = 2'b11;
    data[0] = $urandom;
    step(25);
    chk("mid_ptr0", 0, 32'(grant_at(0)), 32'd1);
    chk("mid_ptr1", 0, 32'(grant_at(1)), 32'd2);
    // random traffic with loopback
    rnd_mode = 1'b1;
    step(1500);
    rnd_mode = 1'b0;
    step(200);
    chk("lb_count", 0, 32'(rxq.size()), 32'(sent.size()));
    chk("lb_done", 0, 32'(done0), 32'(sent.size()));
    for (int k = 0; k < sent.size(); k++)
      chk("lb_byte", k, k < rxq.size() ? 32'(rxq[k]) : 32'hxxxxxxxx, 32'(sent[k]));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Shares one serial transmit line among `N_REQ` byte requesters using round-robin arbitration. Each granted byte is serialised as an idle-high frame: one start bit (0), 8 data bits LSB first, and one stop bit (1). The frame format matches the team's serial frame receiver, so the two blocks form a loopback pair. The block sits between on-chip producers (status, debug, command responders) and the board-level serial pin.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `BIT_CYCLES`, default 1: clocks per serial bit, 1..65535.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `req`  in  N_REQ  per-requester request level.
- `data`  in  8*N_REQ  requester i byte at bits [8i+7:8i].
- `ack`  out  N_REQ  one-hot, one-cycle pulse; data of that requester captured.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while any frame is in progress (states START/DATA/STOP).
- `frame_done`  out  1  one-cycle pulse in the last clock of a stop bit.

## Operation
- States:
  - IDLE: tx=1.
  - START: tx=0, one bit period.
  - DATA: 8 bit periods; tx=shift[0], shift right at each bit boundary.
  - STOP: tx=1, one bit period.
- Bit timer counts 0..BIT_CYCLES-1. A bit boundary occurs when the timer equals BIT_CYCLES-1.
- Data bit index counts 0..7. DATA→STOP at the boundary where index=7.
- Arbitration decision points:
  - every IDLE cycle;
  - the final cycle of STOP.
- Grant rule:
  - The winner is the first asserted `req` searching from `last+1` upward, wrapping modulo N_REQ.
  - `last` is updated to the winner index.
- Transitions:
  - On a grant, the next state is START. The shift register loads `data[winner]` and the bit timer clears.
  - At the end of STOP with no request, the next state is IDLE.
  - There is no idle gap between back-to-back frames; frames are 10*BIT_CYCLES cycles each.
- Request handshake:
  - A requester holds `req` high and `data` stable until it sees its `ack`.
  - It may deassert `req` in the cycle after `ack`.
  - `req` still high in the cycle after `ack` counts as a new request. It is eligible at the next decision point.
  - A `req` dropped before `ack` is a protocol violation. It is ignored if it is low at the decision point.
- The `req` and `data` of a requester that is not granted are don't-care.
- `busy` = (state != IDLE).
- `frame_done` is high for exactly one cycle per frame.

## Timing
- Reset values:
  - state = IDLE;
  - `tx` = 1;
  - `ack` = 0;
  - `busy` = 0;
  - `frame_done` = 0;
  - `last` = N_REQ-1, so requester 0 has highest priority after reset.
  - Bit timer and bit index = 0.
- All outputs are registered.
- Frame launch, with `req[i]` sampled high in IDLE at cycle t:
  - At cycle t+1: state=START, `tx`=0, `ack[i]`=1 for that cycle only, `busy`=1.
  - Data bit k occupies cycles t+1+(k+1)*BIT_CYCLES .. t+(k+2)*BIT_CYCLES.
  - Stop bit occupies cycles t+1+9*BIT_CYCLES .. t+10*BIT_CYCLES.
  - `frame_done` is high at cycle t+10*BIT_CYCLES.
- Back-to-back frames: the next START begins at t+10*BIT_CYCLES+1, with the new `ack` in that cycle.
- Reset mid-frame:
  - The frame is abandoned and `tx` is 1 from the next cycle.
  - No `frame_done` is issued.
  - The interrupted requester is not re-acked. It was already acked, so the byte is lost, as the system design accepts.
- Simultaneous reset and request: reset wins; arbitration restarts in IDLE.
- `data` changes after `ack` do not affect the frame in flight.

## Structure
- Shared package `serial_pkg`:
  - state enum `ser_state_t` {IDLE, START, DATA, STOP};
  - `SER_DATA_BITS` = 8;
  - `SER_IDLE_LEVEL` = 1'b1.
  - The receiver side uses the same package.
- Sub-module `rr_arbiter`:
  - Parameter `N`; inputs `req`, `last`; outputs `grant_valid` and `grant_idx`.
  - Combinational priority rotate.
  - Reusable by other shared-resource controllers.
- Top level holds the FSM, bit timer, bit index, shift register, `last` register and output registers.

## Test plan
- Single request, BIT_CYCLES=1:
  - Stimulus: `req[2]`=1 with `data[2]`=8'hA5.
  - Required: `ack[2]` one cycle. `tx` sequence 0,1,0,1,0,0,1,0,1,1. `frame_done` once. Then IDLE with `tx`=1.
- All four requesting from reset, each held until its ack:
  - Required: acks in order 0,1,2,3.
  - Four frames back-to-back, 40 cycles total, with no `tx`=1 idle cycle between frames.
- Fairness:
  - Stimulus: `req[0]` held high continuously, `req[3]` asserted once.
  - Required: `req[3]` is acked after at most one requester-0 frame. Grants alternate 0,3,0.
- BIT_CYCLES=4, single byte 8'h01:
  - Required: start bit low for 4 cycles, data bit 0 high for 4 cycles, remaining data bits low.
  - `frame_done` at cycle t+40.
- Reset mid-frame:
  - Stimulus: assert reset during data bit 3.
  - Required: `tx`=1, `busy`=0 and `ack`=0 the next cycle. No `frame_done`.
  - A later `req[1]` is granted before `req[2]`, confirming the pointer reset.
- Loopback:
  - Stimulus: drive `tx` into the serial frame receiver for random bytes across all requesters.
  - Required: one receiver done pulse per `frame_done`, and received bytes match in grant order.
